ulpb_lc_power_sequencer: RTL and testbench

//  Always-on sequencer driving LC power-gating controls through the BC/LC isolation stage.

---
 rtl/ulpb_lc_power_sequencer_pkg.sv | 57 +++++
 rtl/ulpb_lc_power_sequencer_dwell_counter.sv | 27 ++
 rtl/ulpb_lc_power_sequencer.sv | 111 +++++++++++
 tb/tb_ulpb_lc_power_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ulpb_lc_power_sequencer_pkg.sv
// Shared definitions for the LC power sequencer: control levels, state encodings
// and the state-to-control decode used by the sequencer and its neighbours.
package ulpb_lc_power_sequencer_pkg;

   localparam logic IO_HOLD    = 1'b0;
   localparam logic IO_RELEASE = 1'b1;

   localparam int LC_PWR_STATE_WIDTH = 4;

   typedef enum logic [LC_PWR_STATE_WIDTH-1:0] {
      ST_SLEEP  = 4'd0,
      ST_UP_PWR = 4'd1,
      ST_UP_CLK = 4'd2,
      ST_UP_RST = 4'd3,
      ST_UP_ISO = 4'd4,
      ST_ACTIVE = 4'd5,
      ST_DN_ISO = 4'd6,
      ST_DN_RST = 4'd7,
      ST_DN_CLK = 4'd8,
      ST_DN_PWR = 4'd9
   } lc_pwr_state_t;

   typedef struct packed {
      logic power_on;
      logic release_clk;
      logic release_rst;
      logic release_iso;
      logic lc_active;
      logic seq_busy;
   } lc_ctrl_t;

   localparam lc_ctrl_t CTRL_IDLE = '{IO_HOLD, IO_HOLD, IO_HOLD, IO_HOLD, 1'b0, 1'b0};

   function automatic logic is_wake_chain(input lc_pwr_state_t s);
      return (s == ST_UP_PWR) || (s == ST_UP_CLK) || (s == ST_UP_RST) || (s == ST_UP_ISO);
   endfunction

   // Each state fully determines the four LC controls; anything unknown decodes to idle.
   function automatic lc_ctrl_t decode_ctrl(input lc_pwr_state_t s);
      lc_ctrl_t c;
      c = CTRL_IDLE;
      case (s)
         ST_UP_PWR: c = '{IO_RELEASE, IO_HOLD,    IO_HOLD,    IO_HOLD,    1'b0, 1'b1};
         ST_UP_CLK: c = '{IO_RELEASE, IO_RELEASE, IO_HOLD,    IO_HOLD,    1'b0, 1'b1};
         ST_UP_RST: c = '{IO_RELEASE, IO_RELEASE, IO_RELEASE, IO_HOLD,    1'b0, 1'b1};
         ST_UP_ISO: c = '{IO_RELEASE, IO_RELEASE, IO_RELEASE, IO_RELEASE, 1'b0, 1'b1};
         ST_ACTIVE: c = '{IO_RELEASE, IO_RELEASE, IO_RELEASE, IO_RELEASE, 1'b1, 1'b0};
         ST_DN_ISO: c = '{IO_RELEASE, IO_RELEASE, IO_RELEASE, IO_HOLD,    1'b0, 1'b1};
         ST_DN_RST: c = '{IO_RELEASE, IO_RELEASE, IO_HOLD,    IO_HOLD,    1'b0, 1'b1};
         ST_DN_CLK: c = '{IO_RELEASE, IO_HOLD,    IO_HOLD,    IO_HOLD,    1'b0, 1'b1};
         ST_DN_PWR: c = '{IO_HOLD,    IO_HOLD,    IO_HOLD,    IO_HOLD,    1'b0, 1'b1};
         default:   c = CTRL_IDLE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/ulpb_lc_power_sequencer_dwell_counter.sv
// Down-counter timing how long the sequencer dwells in each step.
// Loads on entry to a step, counts down to zero and then holds there.
module ulpb_dwell_counter #(
   parameter int DLY_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [DLY_WIDTH-1:0] load_val,
   output logic                 zero
);

   logic [DLY_WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/ulpb_lc_power_sequencer.sv
// Always-on LC power sequencer: walks power, clock, reset and isolation controls
// up on wake and back down in reverse order on sleep, dwelling a set time per step.
module ulpb_lc_power_sequencer
   import ulpb_lc_power_sequencer_pkg::*;
#(
   parameter int DLY_WIDTH = 4,
   parameter int PWR_DLY   = 8,
   parameter int CLK_DLY   = 2,
   parameter int RST_DLY   = 2,
   parameter int ISO_DLY   = 1
) (
   input  logic CLK,
   input  logic RESETn,
   input  logic WAKE_REQ,
   input  logic SLEEP_REQ,
   output logic POWER_ON,
   output logic RELEASE_CLK,
   output logic RELEASE_RST,
   output logic RELEASE_ISO,
   output logic LC_ACTIVE,
   output logic SEQ_BUSY
);

   localparam logic [DLY_WIDTH-1:0] PWR_LOAD = DLY_WIDTH'(PWR_DLY);
   localparam logic [DLY_WIDTH-1:0] CLK_LOAD = DLY_WIDTH'(CLK_DLY);
   localparam logic [DLY_WIDTH-1:0] RST_LOAD = DLY_WIDTH'(RST_DLY);
   localparam logic [DLY_WIDTH-1:0] ISO_LOAD = DLY_WIDTH'(ISO_DLY);

   lc_pwr_state_t        state;
   lc_pwr_state_t        next_state;
   logic                 sleep_pend;
   logic                 next_pend;
   logic                 load;
   logic [DLY_WIDTH-1:0] load_val;
   logic                 dwell_done;
   lc_ctrl_t             ctrl;

   ulpb_dwell_counter #(
      .DLY_WIDTH(DLY_WIDTH)
   ) u_dwell (
      .clk      (CLK),
      .rst_n    (RESETn),
      .load     (load),
      .load_val (load_val),
      .zero     (dwell_done)
   );

   // Controls are registered from the next-state decode so they change on the
   // same edge as the state, with no path from the request inputs to the pins.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state      <= ST_SLEEP;
         sleep_pend <= 1'b0;
         ctrl       <= CTRL_IDLE;
      end else begin
         state      <= next_state;
         sleep_pend <= next_pend;
         ctrl       <= decode_ctrl(next_state);
      end
   end

   // A sleep request during power-up is only remembered; the chain always finishes.
   always_comb begin
      next_state = state;
      next_pend  = sleep_pend;
      case (state)
         ST_SLEEP:  if (WAKE_REQ)   next_state = ST_UP_PWR;
         ST_UP_PWR: if (dwell_done) next_state = ST_UP_CLK;
         ST_UP_CLK: if (dwell_done) next_state = ST_UP_RST;
         ST_UP_RST: if (dwell_done) next_state = ST_UP_ISO;
         ST_UP_ISO: if (dwell_done) next_state = ST_ACTIVE;
         ST_ACTIVE: if (SLEEP_REQ || sleep_pend) next_state = ST_DN_ISO;
         ST_DN_ISO: if (dwell_done) next_state = ST_DN_RST;
         ST_DN_RST: if (dwell_done) next_state = ST_DN_CLK;
         ST_DN_CLK: if (dwell_done) next_state = ST_DN_PWR;
         ST_DN_PWR: if (dwell_done) next_state = ST_SLEEP;
         default:   next_state = ST_SLEEP;
      endcase
      if (is_wake_chain(state) && SLEEP_REQ) begin
         next_pend = 1'b1;
      end
      if ((next_state == ST_DN_ISO) || (next_state == ST_SLEEP)) begin
         next_pend = 1'b0;
      end
   end

   always_comb begin
      load     = (next_state != state);
      load_val = '0;
      case (next_state)
         ST_UP_PWR, ST_DN_PWR: load_val = PWR_LOAD;
         ST_UP_CLK, ST_DN_CLK: load_val = CLK_LOAD;
         ST_UP_RST, ST_DN_RST: load_val = RST_LOAD;
         ST_UP_ISO, ST_DN_ISO: load_val = ISO_LOAD;
         default:              load_val = '0;
      endcase
   end

   assign POWER_ON    = ctrl.power_on;
   assign RELEASE_CLK = ctrl.release_clk;
   assign RELEASE_RST = ctrl.release_rst;
   assign RELEASE_ISO = ctrl.release_iso;
   assign LC_ACTIVE   = ctrl.lc_active;
   assign SEQ_BUSY    = ctrl.seq_busy;

   a_release_order: assert property (@(posedge CLK) disable iff (!RESETn)
      ((RELEASE_ISO != IO_RELEASE) || (RELEASE_RST == IO_RELEASE)) &&
      ((RELEASE_RST != IO_RELEASE) || (RELEASE_CLK == IO_RELEASE)) &&
      ((RELEASE_CLK != IO_RELEASE) || (POWER_ON == IO_RELEASE)));

endmodule

// File: tb/tb_ulpb_lc_power_sequencer.sv
// Directed bench for the LC power sequencer: one instance with default dwells,
// one with all dwells zero, checked cycle by cycle against hand-derived timelines.
module tb_ulpb_lc_power_sequencer;

   localparam int P = 8;
   localparam int C = 2;
   localparam int R = 2;
   localparam int I = 1;

   logic CLK = 1'b0;
   logic RESETn = 1'b0;
   logic wake_a = 1'b0;
   logic sleep_a = 1'b0;
   logic wake_z = 1'b0;
   logic sleep_z = 1'b0;
   logic power_on_a, release_clk_a, release_rst_a, release_iso_a, lc_active_a, seq_busy_a;
   logic power_on_z, release_clk_z, release_rst_z, release_iso_z, lc_active_z, seq_busy_z;

   int n_checks = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   ulpb_lc_power_sequencer #(
      .DLY_WIDTH(4), .PWR_DLY(P), .CLK_DLY(C), .RST_DLY(R), .ISO_DLY(I)
   ) dut_a (
      .CLK         (CLK),
      .RESETn      (RESETn),
      .WAKE_REQ    (wake_a),
      .SLEEP_REQ   (sleep_a),
      .POWER_ON    (power_on_a),
      .RELEASE_CLK (release_clk_a),
      .RELEASE_RST (release_rst_a),
      .RELEASE_ISO (release_iso_a),
      .LC_ACTIVE   (lc_active_a),
      .SEQ_BUSY    (seq_busy_a)
   );

   ulpb_lc_power_sequencer #(
      .DLY_WIDTH(4), .PWR_DLY(0), .CLK_DLY(0), .RST_DLY(0), .ISO_DLY(0)
   ) dut_z (
      .CLK         (CLK),
      .RESETn      (RESETn),
      .WAKE_REQ    (wake_z),
      .SLEEP_REQ   (sleep_z),
      .POWER_ON    (power_on_z),
      .RELEASE_CLK (release_clk_z),
      .RELEASE_RST (release_rst_z),
      .RELEASE_ISO (release_iso_z),
      .LC_ACTIVE   (lc_active_z),
      .SEQ_BUSY    (seq_busy_z)
   );

   // Observed vector order: {POWER_ON, RELEASE_CLK, RELEASE_RST, RELEASE_ISO, LC_ACTIVE, SEQ_BUSY}
   function automatic logic [5:0] obsOf(input bit zsel);
      if (zsel)
         return {power_on_z, release_clk_z, release_rst_z, release_iso_z, lc_active_z, seq_busy_z};
      return {power_on_a, release_clk_a, release_rst_a, release_iso_a, lc_active_a, seq_busy_a};
   endfunction

   // Expected controls k edges after WAKE_REQ is first sampled in SLEEP.
   function automatic logic [5:0] expWake(input int k, input int p, input int c, input int r, input int i);
      int tp, tc, tr, ti, ta;
      logic [5:0] v;
      tp = 1;
      tc = tp + p + 1;
      tr = tc + c + 1;
      ti = tr + r + 1;
      ta = ti + i + 1;
      v[5] = (k >= tp);
      v[4] = (k >= tc);
      v[3] = (k >= tr);
      v[2] = (k >= ti);
      v[1] = (k >= ta);
      v[0] = (k >= tp) && (k < ta);
      return v;
   endfunction

   // Expected controls k edges after a sleep request is sampled in ACTIVE.
   function automatic logic [5:0] expSleep(input int k, input int p, input int c, input int r, input int i);
      int ti, tr, tc, tp, ts;
      logic [5:0] v;
      ti = 1;
      tr = ti + i + 1;
      tc = tr + r + 1;
      tp = tc + c + 1;
      ts = tp + p + 1;
      v[5] = (k < tp);
      v[4] = (k < tc);
      v[3] = (k < tr);
      v[2] = (k < ti);
      v[1] = 1'b0;
      v[0] = (k >= 1) && (k < ts);
      return v;
   endfunction

   function automatic logic orderOk(input logic [5:0] v);
      return (!v[2] || v[3]) && (!v[3] || v[4]) && (!v[4] || v[5]) && (!v[1] || v[2]);
   endfunction

   task automatic checkOutput(input string tag, input logic [5:0] observed, input logic [5:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit zsel, input logic wake, input logic sleep);
      if (zsel) begin
         wake_z  = wake;
         sleep_z = sleep;
      end else begin
         wake_a  = wake;
         sleep_a = sleep;
      end
   endtask

   task automatic stepCycle();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic runWake(input bit zsel, input string tag, input int p, input int c, input int r, input int i);
      int lat;
      lat = p + c + r + i + 5;
      applyStimulus(zsel, 1'b1, 1'b0);
      for (int k = 1; k <= lat + 1; k++) begin
         stepCycle();
         if (k == 1) applyStimulus(zsel, 1'b0, 1'b0);
         checkOutput($sformatf("%s_k%0d", tag, k), obsOf(zsel), expWake(k, p, c, r, i));
      end
   endtask

   task automatic runSleep(input bit zsel, input string tag, input int p, input int c, input int r, input int i,
                           input logic hold_wake);
      int lat;
      int last;
      lat = p + c + r + i + 5;
      last = hold_wake ? 2 * lat + 1 : lat + 1;
      applyStimulus(zsel, hold_wake, 1'b1);
      for (int k = 1; k <= last; k++) begin
         stepCycle();
         if (k == 1) applyStimulus(zsel, hold_wake, 1'b0);
         if (k <= lat)
            checkOutput($sformatf("%s_k%0d", tag, k), obsOf(zsel), expSleep(k, p, c, r, i));
         else if (hold_wake)
            checkOutput($sformatf("%s_k%0d", tag, k), obsOf(zsel), expWake(k - lat, p, c, r, i));
         else
            checkOutput($sformatf("%s_k%0d", tag, k), obsOf(zsel), 6'b000000);
      end
      applyStimulus(zsel, 1'b0, 1'b0);
   endtask

   // Sleep pulse lands while UP_CLK is the current state.
   task automatic runOverlap(input bit zsel, input string tag, input int p, input int c, input int r, input int i);
      int lat;
      int tc;
      lat = p + c + r + i + 5;
      tc = p + 2;
      applyStimulus(zsel, 1'b1, 1'b0);
      for (int k = 1; k <= 2 * lat + 1; k++) begin
         stepCycle();
         if (k == 1) applyStimulus(zsel, 1'b0, 1'b0);
         if (k == tc) applyStimulus(zsel, 1'b0, 1'b1);
         if (k == tc + 1) applyStimulus(zsel, 1'b0, 1'b0);
         if (k <= lat)
            checkOutput($sformatf("%s_k%0d", tag, k), obsOf(zsel), expWake(k, p, c, r, i));
         else
            checkOutput($sformatf("%s_k%0d", tag, k), obsOf(zsel), expSleep(k - lat, p, c, r, i));
      end
   endtask

   initial begin
      $display("[TB] start");
      repeat (3) @(negedge CLK);
      RESETn = 1'b1;

      for (int k = 1; k <= 50; k++) begin
         stepCycle();
         checkOutput($sformatf("reset_idle_a_k%0d", k), obsOf(0), 6'b000000);
         checkOutput($sformatf("reset_idle_z_k%0d", k), obsOf(1), 6'b000000);
      end

      runWake(0, "wake_a", P, C, R, I);
      runSleep(0, "sleep_a", P, C, R, I, 1'b0);
      runOverlap(0, "overlap_a", P, C, R, I);
      runWake(0, "wake_a2", P, C, R, I);
      runSleep(0, "rewake_a", P, C, R, I, 1'b1);
      runSleep(0, "sleep_a2", P, C, R, I, 1'b0);

      applyStimulus(0, 1'b1, 1'b0);
      for (int k = 1; k <= 14; k++) begin
         stepCycle();
         if (k == 1) applyStimulus(0, 1'b0, 1'b0);
      end
      checkOutput("pre_reset_up_rst", obsOf(0), expWake(14, P, C, R, I));
      #2 RESETn = 1'b0;
      #1;
      checkOutput("async_reset_a", obsOf(0), 6'b000000);
      @(negedge CLK);
      @(negedge CLK);
      RESETn = 1'b1;
      stepCycle();
      checkOutput("post_reset_idle_a", obsOf(0), 6'b000000);
      runWake(0, "wake_after_reset", P, C, R, I);
      runSleep(0, "sleep_after_reset", P, C, R, I, 1'b0);

      runWake(1, "wake_z", 0, 0, 0, 0);
      runSleep(1, "sleep_z", 0, 0, 0, 0, 1'b0);
      runOverlap(1, "overlap_z", 0, 0, 0, 0);

      for (int n = 0; n < 10000; n++) begin
         if ($urandom_range(0, 15) == 0) wake_a = ~wake_a;
         if ($urandom_range(0, 15) == 0) wake_z = ~wake_z;
         sleep_a = ($urandom_range(0, 7) == 0);
         sleep_z = ($urandom_range(0, 7) == 0);
         stepCycle();
         checkOutput($sformatf("order_a_n%0d", n), {5'b00000, orderOk(obsOf(0))}, 6'b000001);
         checkOutput($sformatf("order_z_n%0d", n), {5'b00000, orderOk(obsOf(1))}, 6'b000001);
      end
      applyStimulus(0, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
